// File: rtl/vga_timing_gen_if.sv
// Raster outputs of vga_timing_gen: pixel coordinates, blank/sync strobes and frame bookkeeping.
// The master side is driven by the timing generator; renderer stages and the connector use the slave side.
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output DrawX,
        output DrawY,
        output blank,
        output hs,
        output vs,
        output frame_start,
        output frame_count
    );

    modport slave (
        input DrawX,
        input DrawY,
        input blank,
        input hs,
        input vs,
        input frame_start,
        input frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480 @ 60 Hz by default) running on the pixel clock.
// Define VGA_SYNC_ALIGN_EN to delay hs/vs/blank by PIPE_DEPTH cycles to match renderer latency.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DEPTH = 2
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // hc_r/vc_r point at the pixel that the output registers present on the next cycle.
    logic [9:0] hc_r;
    logic [9:0] vc_r;

    logic       blank_s;
    logic       hs_s;
    logic       vs_s;
    logic       frame_start_s;

    logic [9:0] draw_x_r;
    logic [9:0] draw_y_r;
    logic       blank_r;
    logic       hs_r;
    logic       vs_r;
    logic       frame_start_r;
    logic [7:0] frame_count_r;

    // Free-running horizontal/vertical raster counters.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else if (hc_r == H_LAST) begin
            hc_r <= 10'd0;
            if (vc_r == V_LAST) begin
                vc_r <= 10'd0;
            end else begin
                vc_r <= vc_r + 10'd1;
            end
        end else begin
            hc_r <= hc_r + 10'd1;
        end
    end

    // Decode blank/sync/frame-start for the pixel held in the counters.
    always_comb begin
        blank_s       = (hc_r < H_VIS_END) && (vc_r < V_VIS_END);
        hs_s          = !((hc_r >= HS_START) && (hc_r < HS_END));
        vs_s          = !((vc_r >= VS_START) && (vc_r < VS_END));
        frame_start_s = (hc_r == 10'd0) && (vc_r == 10'd0);
    end

    // Output registers: every field for one pixel updates on the same edge.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            draw_x_r      <= 10'd0;
            draw_y_r      <= 10'd0;
            blank_r       <= 1'b0;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            frame_start_r <= 1'b0;
            frame_count_r <= 8'd0;
        end else begin
            draw_x_r      <= hc_r;
            draw_y_r      <= vc_r;
            blank_r       <= blank_s;
            hs_r          <= hs_s;
            vs_r          <= vs_s;
            frame_start_r <= frame_start_s;
            // The presented pixel leaves the last position of the frame on this edge.
            if ((draw_x_r == H_LAST) && (draw_y_r == V_LAST)) begin
                frame_count_r <= frame_count_r + 8'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign vga.DrawX       = draw_x_r;
    assign vga.DrawY       = draw_y_r;
    assign vga.frame_start = frame_start_r;
    assign vga.frame_count = frame_count_r;

`ifdef VGA_SYNC_ALIGN_EN
    logic [PIPE_DEPTH-1:0] blank_pipe_r;
    logic [PIPE_DEPTH-1:0] hs_pipe_r;
    logic [PIPE_DEPTH-1:0] vs_pipe_r;

    // Delay line for blank/sync; stages reset to their inactive levels.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blank_pipe_r <= {PIPE_DEPTH{1'b0}};
            hs_pipe_r    <= {PIPE_DEPTH{1'b1}};
            vs_pipe_r    <= {PIPE_DEPTH{1'b1}};
        end else begin
            blank_pipe_r[0] <= blank_r;
            hs_pipe_r[0]    <= hs_r;
            vs_pipe_r[0]    <= vs_r;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                blank_pipe_r[i] <= blank_pipe_r[i-1];
                hs_pipe_r[i]    <= hs_pipe_r[i-1];
                vs_pipe_r[i]    <= vs_pipe_r[i-1];
            end
        end
    end

    assign vga.blank = blank_pipe_r[PIPE_DEPTH-1];
    assign vga.hs    = hs_pipe_r[PIPE_DEPTH-1];
    assign vga.vs    = vs_pipe_r[PIPE_DEPTH-1];
`else
    assign vga.blank = blank_r;
    assign vga.hs    = hs_r;
    assign vga.vs    = vs_r;
`endif
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock.
- Drives `DrawX`/`DrawY`/`blank` into the background renderer and sprite stages.
- Drives `hs`/`vs` to the VGA connector.
- Provides a start-of-frame pulse and a free-running frame counter for animation logic.
- Can optionally delay sync and blank to match the renderer's pipeline latency.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `PIPE_DEPTH`, 2, sync/blank delay in cycles when alignment is compiled in; must be ≥1

Ports:
- `vga_clk`  in  1  pixel clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `DrawX`  out  10  current column
- `DrawY`  out  10  current line
- `blank`  out  1  1 = visible region (renderer drives colour), 0 = blanking
- `hs`  out  1  horizontal sync, active low
- `vs`  out  1  vertical sync, active low
- `frame_start`  out  1  one-cycle pulse at pixel (0,0)
- `frame_count`  out  8  completed-frame counter, wraps 255→0

## Operation
- Derived totals: `H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK` (800); `V_TOTAL` = 525.
- Horizontal counter `hc`: 0..H_TOTAL-1, increments every cycle, wraps to 0.
- Vertical counter `vc`: increments only when `hc == H_TOTAL-1`; wraps to 0 after V_TOTAL-1 on that same cycle.
- `DrawX = hc` and `DrawY = vc`, including during blanking. Values reach 799/524; downstream stages gate on `blank`.
- `blank` = 1 iff `hc < H_VISIBLE` and `vc < V_VISIBLE`.
- `hs` = 0 iff `H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC`, i.e. 656..751.
- `vs` = 0 iff `V_VISIBLE+V_FRONT ≤ vc < V_VISIBLE+V_FRONT+V_SYNC`, i.e. 490..491.
- `frame_start` = 1 for exactly the cycle where `hc == 0 && vc == 0`.
- `frame_count` increments by 1 on the cycle where `hc == H_TOTAL-1 && vc == V_TOTAL-1`. It wraps modulo 256.
- All outputs are registered, with no combinational path from `reset` to any output.

## Timing
- Reset, while asserted:
  - `hc = vc = 0`, `DrawX = DrawY = 0`
  - `hs = 1`, `vs = 1`, `blank = 0`
  - `frame_start = 0`, `frame_count = 0`
  - all alignment shift-register stages hold their inactive values (`hs = 1`, `vs = 1`, `blank = 0`)
- First cycle after reset deasserts:
  - `DrawX = 0`, `DrawY = 0`, `frame_start = 1`
  - `blank = 1` (without alignment)
- Reset asserted mid-frame: outputs take reset values on the next edge. The frame restarts at (0,0) with no partial-sync glitch beyond the reset values above. `frame_count` clears.
- Outputs for a given (`hc`,`vc`) are all valid in the same cycle, i.e. zero skew between `DrawX`/`DrawY` and the undelayed `blank`/`hs`/`vs`.
- Line period is 800 cycles; frame period is 420 000 cycles.
- `hs` low for 96 consecutive cycles per line; `vs` low for 1600 consecutive cycles per frame.
- Line/frame boundary at `hc == 799, vc == 524`: in the same edge, `hc→0`, `vc→0`, `frame_count` increments, and next-cycle `frame_start = 1`.

## Configuration
- Macro `VGA_SYNC_ALIGN_EN`.
- Defined:
  - `hs`, `vs` and `blank` pass through a `PIPE_DEPTH`-stage shift register.
  - This lines them up with a renderer that has a 1-cycle ROM read plus a 1-cycle output register.
  - `DrawX`, `DrawY`, `frame_start` and `frame_count` are not delayed.
  - After reset, delayed outputs show inactive values for `PIPE_DEPTH` cycles.
  - Delayed `blank` first rises on cycle `PIPE_DEPTH` after reset release.
- Not defined: no delay stages; `hs`, `vs` and `blank` align with `DrawX`/`DrawY` as described above.

## Test plan
- Reset held 5 cycles, then released:
  - during reset, all outputs at reset values
  - cycle 0 after release: `DrawX=0`, `DrawY=0`, `frame_start=1`, `blank=1`
  - cycle 1: `frame_start=0`, `DrawX=1`
- Run one line:
  - `blank` 1 for `DrawX` 0..639, 0 for 640..799
  - `hs` low exactly for `DrawX` 656..751
  - `DrawY` increments only at the 799→0 wrap
- Run two full frames:
  - `vs` low only at `DrawY` 490..491
  - `frame_start` pulses exactly twice, 420 000 cycles apart
  - `frame_count` reads 2 at start of the third frame
- Run 256 frames: `frame_count` wraps 255→0 on the same edge that `DrawY` 524→0.
- Assert reset at (`DrawX=700`, `DrawY=491`) during both syncs:
  - next cycle `hs=1`, `vs=1`, `blank=0`, counters 0
  - after release, frame restarts at (0,0)
- With `VGA_SYNC_ALIGN_EN`, `PIPE_DEPTH=2`:
  - `blank` rises 2 cycles after `DrawX=0` of line 0
  - `hs` falls when `DrawX=658`
  - `DrawX` timing is identical to the undefined build
